// File: rtl/sm4_rk_buffer.sv
// SM4 round-key buffer: captures ROUNDS keys in generation order, then serves
// them forward (encrypt) or reversed (decrypt) with a valid/ready handshake.
module sm4_rk_buffer #(
  parameter int WORD_WIDTH = 32,
  parameter int ROUNDS     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  wr_valid,
  input  logic [WORD_WIDTH-1:0] wr_rk,
  output logic                  wr_ready,
  output logic                  keys_ready,
  input  logic                  rd_start,
  input  logic                  rd_decrypt,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [WORD_WIDTH-1:0] rd_rk,
  output logic                  rd_last
);

  localparam int PTR_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(ROUNDS - 1);
  localparam logic [PTR_W-1:0] ONE      = PTR_W'(1);

  typedef enum logic [1:0] {EMPTY, FILL, FULL, READ} state_t;

  state_t                state;
  state_t                state_nxt;
  logic [WORD_WIDTH-1:0] mem [ROUNDS];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      rd_ptr_nxt;
  logic [PTR_W-1:0]      start_idx;
  logic [PTR_W-1:0]      start_end;
  logic [PTR_W-1:0]      pass_end;
  logic                  dec;
  logic                  wr_fire;
  logic                  start_fire;
  logic                  rd_fire;

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    wr_ready   = 1'b0;
    keys_ready = 1'b0;
    case (state)
      EMPTY, FILL: begin
        wr_ready = 1'b1;
        if (wr_valid) state_nxt = (wr_ptr == LAST_IDX) ? FULL : FILL;
      end
      FULL: begin
        keys_ready = 1'b1;
        if (rd_start) state_nxt = READ;
      end
      READ: begin
        keys_ready = 1'b1;
        if (rd_valid && rd_ready && rd_last) state_nxt = FULL;
      end
      default: state_nxt = EMPTY;
    endcase
    if (clear) state_nxt = EMPTY;
  end

  // Handshake qualifiers; clear and rst suppress every side effect.
  assign wr_fire    = wr_ready && wr_valid && !clear && !rst;
  assign start_fire = (state == FULL) && rd_start && !clear;
  assign rd_fire    = rd_valid && rd_ready && !clear;

  assign start_idx  = rd_decrypt ? LAST_IDX : '0;
  assign start_end  = rd_decrypt ? '0 : LAST_IDX;
  assign pass_end   = dec ? '0 : LAST_IDX;
  assign rd_ptr_nxt = dec ? (rd_ptr - ONE) : (rd_ptr + ONE);

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr] <= wr_rk;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      dec      <= 1'b0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      rd_rk    <= '0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
    end else begin
      if (wr_fire) wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : (wr_ptr + ONE);
      if (start_fire) begin
        dec      <= rd_decrypt;
        rd_ptr   <= start_idx;
        rd_rk    <= mem[start_idx];
        rd_valid <= 1'b1;
        rd_last  <= (start_idx == start_end);
      end else if (rd_fire) begin
        // rd_ptr stops on the final key so the pass never wraps.
        if (rd_last) begin
          rd_valid <= 1'b0;
          rd_last  <= 1'b0;
        end else begin
          rd_ptr  <= rd_ptr_nxt;
          rd_rk   <= mem[rd_ptr_nxt];
          rd_last <= (rd_ptr_nxt == pass_end);
        end
      end
    end
  end

endmodule

// File: tb/tb_sm4_rk_buffer.sv
// Bench for sm4_rk_buffer: queue-based reference model checked every cycle,
// directed scenarios with literal key sequences, then randomized traffic.
module tb_sm4_rk_buffer;
  localparam int W = 32;
  localparam int R = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         clear = 1'b0;
  logic         wr_valid = 1'b0;
  logic [W-1:0] wr_rk = '0;
  logic         wr_ready;
  logic         keys_ready;
  logic         rd_start = 1'b0;
  logic         rd_decrypt = 1'b0;
  logic         rd_valid;
  logic         rd_ready = 1'b0;
  logic [W-1:0] rd_rk;
  logic         rd_last;

  sm4_rk_buffer #(.WORD_WIDTH(W), .ROUNDS(R)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .wr_valid(wr_valid), .wr_rk(wr_rk), .wr_ready(wr_ready),
    .keys_ready(keys_ready),
    .rd_start(rd_start), .rd_decrypt(rd_decrypt),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_rk(rd_rk), .rd_last(rd_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: stored keys by count, and the remaining keys of a pass.
  logic [W-1:0] m_mem [R];
  int           m_count = 0;
  logic [W-1:0] m_pass[$];
  bit           m_rk_zero = 1'b0;
  logic [W-1:0] dut_rk_q[$];
  logic         dut_last_q[$];

  always @(posedge clk) begin
    if (rd_valid && rd_ready && !rst && !clear) begin
      dut_rk_q.push_back(rd_rk);
      dut_last_q.push_back(rd_last);
    end
    if (rst) begin
      m_count = 0;
      m_pass.delete();
      m_rk_zero = 1'b1;
    end else if (clear) begin
      m_count = 0;
      m_pass.delete();
    end else begin
      if (m_pass.size() > 0) begin
        if (rd_ready) void'(m_pass.pop_front());
      end else if (m_count == R && rd_start) begin
        m_rk_zero = 1'b0;
        for (int i = 0; i < R; i++) m_pass.push_back(rd_decrypt ? m_mem[R-1-i] : m_mem[i]);
      end
      if (m_count < R && wr_valid) begin
        m_mem[m_count] = wr_rk;
        m_count++;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("wr_ready", 32'(wr_ready), 32'(m_count < R));
      chk("keys_ready", 32'(keys_ready), 32'(m_count == R));
      chk("rd_valid", 32'(rd_valid), 32'(m_pass.size() > 0));
      if (m_pass.size() > 0) begin
        chk("rd_rk", rd_rk, m_pass[0]);
        chk("rd_last", 32'(rd_last), 32'(m_pass.size() == 1));
      end else begin
        chk("rd_last_idle", 32'(rd_last), 32'd0);
      end
      if (m_rk_zero) chk("rd_rk_reset", rd_rk, 32'd0);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic write_keys(input logic [31:0] base, input int first, input int n);
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      wr_rk = base + 32'(first + i);
      cyc();
    end
    wr_valid = 1'b0;
  endtask

  task automatic run_pass(input bit dec, input bit stall, input logic [31:0] base, input string tag);
    int c;
    bit done;
    done = 1'b0;
    dut_rk_q.delete();
    dut_last_q.delete();
    rd_decrypt = dec;
    rd_start = 1'b1;
    cyc();
    rd_start = 1'b0;
    for (c = 0; c < 200 && !done; c++) begin
      rd_ready = stall ? (c % 2 == 0) : 1'b1;
      cyc();
      if (dut_rk_q.size() == R) done = 1'b1;
    end
    rd_ready = 1'b0;
    chk({tag, "_count"}, 32'(dut_rk_q.size()), 32'(R));
    if (!stall) chk({tag, "_cycles"}, 32'(c), 32'(R));
    for (int i = 0; i < dut_rk_q.size(); i++) begin
      chk({tag, "_rk"}, dut_rk_q[i], dec ? base + 32'(R - 1 - i) : base + 32'(i));
      chk({tag, "_last"}, 32'(dut_last_q[i]), 32'(i == R - 1));
    end
  endtask

  initial begin
    do_reset();
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_wr_ready", 32'(wr_ready), 32'd1);
    chk("reset_keys_ready", 32'(keys_ready), 32'd0);
    chk("reset_rd_valid", 32'(rd_valid), 32'd0);
    chk("reset_rd_rk", rd_rk, 32'd0);

    // Fill with 0x1000_0000 + i, then forward and stalled reverse passes.
    write_keys(32'h1000_0000, 0, R);
    @(negedge clk);
    chk("full_keys_ready", 32'(keys_ready), 32'd1);
    chk("full_wr_ready", 32'(wr_ready), 32'd0);
    run_pass(1'b0, 1'b0, 32'h1000_0000, "enc");
    run_pass(1'b1, 1'b1, 32'h1000_0000, "dec_stall");

    // rd_start during FILL and wr_valid during READ are both ignored.
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    write_keys(32'h1000_0000, 0, 10);
    rd_start = 1'b1;
    cyc();
    rd_start = 1'b0;
    @(negedge clk);
    chk("fill_start_rd_valid", 32'(rd_valid), 32'd0);
    write_keys(32'h1000_0000, 10, R - 10);
    wr_valid = 1'b1;
    wr_rk = 32'hDEAD_BEEF;
    run_pass(1'b0, 1'b0, 32'h1000_0000, "enc_wr_ignored");
    wr_valid = 1'b0;
    run_pass(1'b0, 1'b0, 32'h1000_0000, "enc_again");

    // Clear while the 5th key is being served.
    dut_rk_q.delete();
    dut_last_q.delete();
    rd_decrypt = 1'b0;
    rd_start = 1'b1;
    cyc();
    rd_start = 1'b0;
    rd_ready = 1'b1;
    repeat (4) cyc();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    rd_ready = 1'b0;
    @(negedge clk);
    chk("clear_rd_valid", 32'(rd_valid), 32'd0);
    chk("clear_keys_ready", 32'(keys_ready), 32'd0);
    chk("clear_wr_ready", 32'(wr_ready), 32'd1);
    chk("clear_served", 32'(dut_rk_q.size()), 32'd4);
    write_keys(32'h2000_0000, 0, R);
    run_pass(1'b0, 1'b0, 32'h2000_0000, "refill_enc");

    // Reset mid-FILL, then a complete fresh fill.
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    write_keys(32'h3000_0000, 0, 7);
    do_reset();
    @(negedge clk);
    chk("rst_fill_wr_ready", 32'(wr_ready), 32'd1);
    chk("rst_fill_rd_rk", rd_rk, 32'd0);
    write_keys(32'h4000_0000, 0, R - 1);
    @(negedge clk);
    chk("rst_fill_31_keys_ready", 32'(keys_ready), 32'd0);
    write_keys(32'h4000_0000, R - 1, 1);
    @(negedge clk);
    chk("rst_fill_32_keys_ready", 32'(keys_ready), 32'd1);
    run_pass(1'b1, 1'b0, 32'h4000_0000, "rst_fill_dec");

    // Randomized traffic checked by the model every cycle.
    for (int n = 0; n < 3000; n++) begin
      rst        = ($urandom_range(0, 299) == 0);
      clear      = ($urandom_range(0, 119) == 0);
      wr_valid   = ($urandom_range(0, 1) == 1);
      wr_rk      = $urandom;
      rd_start   = ($urandom_range(0, 5) == 0);
      rd_decrypt = ($urandom_range(0, 1) == 1);
      rd_ready   = ($urandom_range(0, 9) < 7);
      cyc();
    end
    rst = 1'b0;
    clear = 1'b0;
    wr_valid = 1'b0;
    rd_start = 1'b0;
    rd_ready = 1'b0;
    cyc();
    @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sm4_rk_buffer.md
SM4_RK_BUFFER -- requirements
Module: sm4_rk_buffer

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 32, round-key word width.
REQ-002 SHALL have parameter ROUNDS, default 32, number of round keys stored.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port clear  input  1  synchronous flush; discards stored keys.
REQ-006 SHALL have port wr_valid  input  1  producer offers a round key.
REQ-007 SHALL have port wr_rk  input  WORD_WIDTH  round key rk[i], written in generation order i=0..ROUNDS-1.
REQ-008 SHALL have port wr_ready  output  1  buffer accepts wr_rk this cycle.
REQ-009 SHALL have port keys_ready  output  1  all ROUNDS keys stored.
REQ-010 SHALL have port rd_start  input  1  one-cycle request to begin a read pass.
REQ-011 SHALL have port rd_decrypt  input  1  sampled with rd_start; 1 = reverse order, 0 = forward order.
REQ-012 SHALL have port rd_valid  output  1  rd_rk holds a valid key.
REQ-013 SHALL have port rd_ready  input  1  consumer (round engine) takes rd_rk.
REQ-014 SHALL have port rd_rk  output  WORD_WIDTH  round key being served.
REQ-015 SHALL have port rd_last  output  1  rd_rk is the final key of the pass.

Function
REQ-016 SHALL store keys in a ROUNDS x WORD_WIDTH register array indexed by write count.
REQ-017 SHALL implement states EMPTY, FILL, FULL, READ.
REQ-018 EMPTY: wr_ready=1; wr_valid&&wr_ready writes entry 0, goes to FILL with wr_ptr=1.
REQ-019 FILL: wr_ready=1; each handshake writes entry wr_ptr, increments wr_ptr; handshake at wr_ptr=ROUNDS-1 goes to FULL.
REQ-020 wr_ready SHALL be 0 in FULL and READ; wr_valid there SHALL be ignored, array unchanged.
REQ-021 keys_ready SHALL be 1 in FULL and READ, 0 in EMPTY and FILL.
REQ-022 FULL: rd_start=1 SHALL go to READ, latch rd_decrypt, load rd_ptr = ROUNDS-1 (decrypt) or 0 (encrypt).
REQ-023 rd_start in EMPTY, FILL or READ SHALL be ignored.
REQ-024 rd_valid SHALL rise the cycle after the accepted rd_start, with rd_rk = array[rd_ptr] registered.
REQ-025 rd_rk, rd_last SHALL hold stable while rd_valid=1 and rd_ready=0.
REQ-026 On rd_valid&&rd_ready, rd_ptr SHALL step by +1 (encrypt) or -1 (decrypt) and next key SHALL appear next cycle; sustained throughput one key/cycle.
REQ-027 rd_last SHALL be 1 exactly when the served key is array[ROUNDS-1] (encrypt) or array[0] (decrypt).
REQ-028 Handshake on rd_last SHALL return to FULL, deassert rd_valid next cycle; keys retained for further passes.
REQ-029 rd_ptr SHALL never wrap; no key served twice or skipped within one pass.
REQ-030 clear=1 SHALL in any state go to EMPTY, zero wr_ptr/rd_ptr, deassert rd_valid/rd_last next cycle; array contents need not be zeroed.
REQ-031 clear and wr_valid in same cycle: clear wins, no write.
REQ-032 clear and rd_start in same cycle: clear wins, no pass starts.

Reset
REQ-033 rst=1 SHALL have priority over clear and all inputs.
REQ-034 After rst: state EMPTY, wr_ptr=0, rd_ptr=0, wr_ready=1, keys_ready=0, rd_valid=0, rd_last=0, rd_rk=0.
REQ-035 rst asserted mid-FILL or mid-READ SHALL abort immediately; next cycle outputs match REQ-034.

Verification
REQ-036 Write rk[i]=32'h1000_0000+i, i=0..31 -> keys_ready=1 after 32nd handshake; wr_ready=0.
REQ-037 rd_start, rd_decrypt=0, rd_ready=1 -> rd_rk 32'h1000_0000..32'h1000_001F on 32 consecutive cycles, rd_last only on 32'h1000_001F, then FULL.
REQ-038 rd_start, rd_decrypt=1, rd_ready toggling 1/0 -> rd_rk 32'h1000_001F down to 32'h1000_0000, each value held through stall cycles, rd_last only on 32'h1000_0000.
REQ-039 rd_start during FILL (10 keys written) and wr_valid during READ -> both ignored; rd_valid stays 0; array unchanged, later pass reproduces REQ-037 sequence.
REQ-040 clear at 5th key of a READ pass -> rd_valid=0 next cycle, keys_ready=0, wr_ready=1; refill with new values served correctly.
REQ-041 rst mid-FILL after 7 writes, then 32 fresh writes -> keys_ready only after 32 new handshakes; pass serves only new values.
